// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scanner: digit limits, blank pattern and hex glyph table.
package ssd_pkg;

  localparam int MAX_DIGITS = 8;
  localparam int IDX_W      = $clog2(MAX_DIGITS);

  typedef logic [IDX_W-1:0] digit_idx_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low glyphs, bit order {a,b,c,d,e,f,g}; letters use the A,b,C,d,E,F forms
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

endpackage

// File: rtl/ssd_scan_ctrl_if.sv
// Host-side bus of the seven-segment scanner; blink_mask exists only when SSD_BLINK_EN is defined.
interface ssd_scan_ctrl_if #(
  parameter int NUM_DIGITS = 8,
  parameter int BRIGHT_W   = 3
);

  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic                    load;
  logic [BRIGHT_W-1:0]     brightness;
`ifdef SSD_BLINK_EN
  logic [NUM_DIGITS-1:0]   blink_mask;
`endif
  logic                    frame_tick;
  logic                    load_busy;

  modport master (
`ifdef SSD_BLINK_EN
    output blink_mask,
`endif
    output digits_in, dp_in, blank_in, load, brightness,
    input  frame_tick, load_busy
  );

  modport slave (
`ifdef SSD_BLINK_EN
    input  blink_mask,
`endif
    input  digits_in, dp_in, blank_in, load, brightness,
    output frame_tick, load_busy
  );

endinterface

// File: rtl/ssd_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module ssd_hex_decode
  import ssd_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  assign seg_n = HEX_SEG[hex];

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed N-digit seven-segment scanner with frame-synchronous double buffering and PWM dimming.
// Per-digit blinking is compiled in only when SSD_BLINK_EN is defined.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_W     = 14,
  parameter int BRIGHT_W   = 3
) (
  input  logic                  board_clk,
  input  logic                  Reset,
  ssd_scan_ctrl_if.slave        bus,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic [6:0]            seg_n,
  output logic                  dp_n
);

  logic [SCAN_W-1:0]       prescaler;
  digit_idx_t              idx;
  logic                    frame_tick_q;
  logic                    load_busy_q;
  logic [4*NUM_DIGITS-1:0] pend_digits;
  logic [4*NUM_DIGITS-1:0] disp_digits;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [NUM_DIGITS-1:0]   pend_blank;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic [NUM_DIGITS-1:0]   disp_blank;
  logic [NUM_DIGITS-1:0]   blink_dark;
  logic                    slot_wrap;
  logic                    frame_wrap;
  logic                    slot_active;
  logic                    lit;
  logic [3:0]              cur_nibble;
  logic [6:0]              dec_seg;
  logic [NUM_DIGITS-1:0]   an_next;
  logic                    dp_next;

  assign slot_wrap  = (prescaler == '1);
  assign frame_wrap = slot_wrap && (idx == digit_idx_t'(NUM_DIGITS - 1));

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      prescaler    <= '0;
      idx          <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      prescaler    <= prescaler + 1'b1;
      frame_tick_q <= frame_wrap;
      if (slot_wrap) begin
        idx <= frame_wrap ? '0 : idx + 1'b1;
      end
    end
  end

  // frame_tick_q marks the first cycle of a frame; display regs only change at its closing edge
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      pend_digits <= '0;
      pend_dp     <= '0;
      pend_blank  <= '1;
      disp_digits <= '0;
      disp_dp     <= '0;
      disp_blank  <= '1;
      load_busy_q <= 1'b0;
    end else if (bus.load && frame_tick_q) begin
      disp_digits <= bus.digits_in;
      disp_dp     <= bus.dp_in;
      disp_blank  <= bus.blank_in;
      load_busy_q <= 1'b0;
    end else if (bus.load) begin
      pend_digits <= bus.digits_in;
      pend_dp     <= bus.dp_in;
      pend_blank  <= bus.blank_in;
      load_busy_q <= 1'b1;
    end else if (frame_tick_q && load_busy_q) begin
      disp_digits <= pend_digits;
      disp_dp     <= pend_dp;
      disp_blank  <= pend_blank;
      load_busy_q <= 1'b0;
    end
  end

  assign bus.frame_tick = frame_tick_q;
  assign bus.load_busy  = load_busy_q;

`ifdef SSD_BLINK_EN
  logic [SCAN_W+8:0] blink_cnt;

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign blink_dark = bus.blink_mask & {NUM_DIGITS{blink_cnt[SCAN_W+8]}};
`else
  assign blink_dark = '0;
`endif

  // Prescaler zero is the dead-time cycle that stops ghosting between adjacent digits
  always_comb begin
    slot_active = (prescaler != '0) &&
                  ((&bus.brightness) || (prescaler[SCAN_W-1 -: BRIGHT_W] < bus.brightness));
    cur_nibble  = '0;
    an_next     = '1;
    dp_next     = 1'b1;
    lit         = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == digit_idx_t'(i)) begin
        cur_nibble = disp_digits[4*i +: 4];
        if (slot_active && !disp_blank[i] && !blink_dark[i]) begin
          an_next[i] = 1'b0;
          dp_next    = ~disp_dp[i];
          lit        = 1'b1;
        end
      end
    end
  end

  ssd_hex_decode u_hex_decode (
    .hex   (cur_nibble),
    .seg_n (dec_seg)
  );

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      an_n  <= '1;
      seg_n <= SEG_BLANK;
      dp_n  <= 1'b1;
    end else begin
      an_n  <= an_next;
      seg_n <= lit ? dec_seg : SEG_BLANK;
      dp_n  <= dp_next;
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Randomised scoreboard bench for ssd_scan_ctrl (4 digits, 16-cycle slots, 2-bit brightness).
module tb_ssd_scan_ctrl;

  localparam int ND    = 4;
  localparam int SW    = 4;
  localparam int BW    = 2;
  localparam int SLOT  = 1 << SW;
  localparam int FRAME = SLOT * ND;

  // Lit segments, active-high, bit order {a,b,c,d,e,f,g}
  localparam logic [6:0] SEG_ON [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  typedef struct packed {
    logic [ND-1:0] an;
    logic [6:0]    seg;
    logic          dp;
    logic          ft;
    logic          busy;
  } obs_t;

  logic          board_clk = 1'b0;
  logic          Reset     = 1'b0;
  logic [ND-1:0] an_n;
  logic [6:0]    seg_n;
  logic          dp_n;

  ssd_scan_ctrl_if #(.NUM_DIGITS(ND), .BRIGHT_W(BW)) bus ();

  ssd_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_W(SW), .BRIGHT_W(BW)) dut (
    .board_clk (board_clk),
    .Reset     (Reset),
    .bus       (bus),
    .an_n      (an_n),
    .seg_n     (seg_n),
    .dp_n      (dp_n)
  );

  always #5 board_clk = ~board_clk;

  int   vectors     = 0;
  int   miscompares = 0;
  obs_t exp_q [$];

  // Reference model: edges since reset give slot position and digit directly
  int            m_n;
  int            m_pos;
  int            m_dig;
  bit            m_on;
  bit            m_boundary;
  bit            m_busy;
  logic [15:0]   m_disp_dig, m_pend_dig;
  logic [ND-1:0] m_disp_dp, m_pend_dp, m_disp_blank, m_pend_blank;
  obs_t          m_e;

  always @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      m_n          = 0;
      m_busy       = 0;
      m_disp_dig   = '0;
      m_disp_dp    = '0;
      m_disp_blank = '1;
      m_pend_dig   = '0;
      m_pend_dp    = '0;
      m_pend_blank = '1;
      exp_q.delete();
    end else begin
      m_pos = m_n % SLOT;
      m_dig = (m_n / SLOT) % ND;
      m_on  = (m_pos != 0) && ((bus.brightness == 2'd3) || ((m_pos / 4) < int'(bus.brightness)))
              && !m_disp_blank[m_dig];
      m_e.an  = m_on ? ND'(~(4'b0001 << m_dig)) : 4'hF;
      m_e.seg = m_on ? ~SEG_ON[m_disp_dig[4*m_dig +: 4]] : 7'h7F;
      m_e.dp  = m_on ? ~m_disp_dp[m_dig] : 1'b1;
      m_boundary = (m_n > 0) && (m_n % FRAME == 0);
      if (bus.load && m_boundary) begin
        m_disp_dig = bus.digits_in; m_disp_dp = bus.dp_in; m_disp_blank = bus.blank_in;
        m_busy = 0;
      end else if (bus.load) begin
        m_pend_dig = bus.digits_in; m_pend_dp = bus.dp_in; m_pend_blank = bus.blank_in;
        m_busy = 1;
      end else if (m_boundary && m_busy) begin
        m_disp_dig = m_pend_dig; m_disp_dp = m_pend_dp; m_disp_blank = m_pend_blank;
        m_busy = 0;
      end
      m_n     = m_n + 1;
      m_e.ft  = (m_n % FRAME == 0);
      m_e.busy = m_busy;
      exp_q.push_back(m_e);
    end
  end

  task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s @%0t: got an=%h seg=%h dp=%b ft=%b busy=%b, want an=%h seg=%h dp=%b ft=%b busy=%b",
               name, $time, act.an, act.seg, act.dp, act.ft, act.busy,
               exp.an, exp.seg, exp.dp, exp.ft, exp.busy);
    end
  endtask

  // Monitor: during reset the pins must already be dark, otherwise pop the model's prediction
  obs_t act_o;
  obs_t dark_o;
  always @(negedge board_clk) begin
    act_o  = '{an: an_n, seg: seg_n, dp: dp_n, ft: bus.frame_tick, busy: bus.load_busy};
    dark_o = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, ft: 1'b0, busy: 1'b0};
    if (Reset) begin
      checkOutput("reset_dark", act_o, dark_o);
    end else if (exp_q.size() > 0) begin
      checkOutput("scan", act_o, exp_q.pop_front());
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge board_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [ND-1:0] dp, input logic [ND-1:0] blank);
    bus.digits_in = d;
    bus.dp_in     = dp;
    bus.blank_in  = blank;
    bus.load      = 1'b1;
    step(1);
    bus.load      = 1'b0;
  endtask

  task automatic waitPhase(input int phase);
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (m_n > 0 && (m_n % FRAME) == phase) return;
      step(1);
    end
    $display("[TB] FAIL wait_phase: phase %0d not reached, got m_n=%0d want phase=%0d", phase, m_n, phase);
    $fatal(1, "[TB] timeout");
  endtask

  task automatic pulseReset();
    #1 Reset = 1'b1;
    step(3);
    Reset = 1'b0;
  endtask

  int r;

  initial begin
    bus.digits_in  = '0;
    bus.dp_in      = '0;
    bus.blank_in   = '0;
    bus.load       = 1'b0;
    bus.brightness = 2'd3;
`ifdef SSD_BLINK_EN
    bus.blink_mask = '0;
`endif
    #1 Reset = 1'b1;
    step(2);
    Reset = 1'b0;

    // Idle after reset: dark pins, periodic frame ticks
    step(200);

    applyStimulus(16'h12AF, 4'h0, 4'h0);
    step(2 * FRAME);
    bus.brightness = 2'd1;
    step(FRAME + 6);
    bus.brightness = 2'd0;
    step(FRAME);
    bus.brightness = 2'd3;

    // Two loads inside one frame: latest wins
    applyStimulus(16'h1111, 4'h5, 4'h0);
    step(5);
    applyStimulus(16'h2222, 4'hA, 4'h0);
    step(2 * FRAME);

    // Load coinciding with frame_tick goes straight to display
    waitPhase(0);
    applyStimulus(16'h9C3E, 4'h3, 4'h4);
    step(FRAME + 10);

    // Reset in the middle of digit 2's slot
    waitPhase(2 * SLOT + 5);
    applyStimulus(16'h4567, 4'h1, 4'h0);
    pulseReset();
    step(FRAME + 20);

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 5);
      case (r)
        0, 1: applyStimulus(16'($urandom), 4'($urandom), 4'($urandom) & 4'($urandom));
        2: begin
          waitPhase(0);
          applyStimulus(16'($urandom), 4'($urandom), 4'($urandom) & 4'($urandom));
        end
        3: bus.brightness = 2'($urandom_range(0, 3));
        4: begin
          applyStimulus(16'($urandom), 4'($urandom), 4'h0);
          applyStimulus(16'($urandom), 4'($urandom), 4'($urandom) & 4'($urandom));
        end
        default: if ($urandom_range(0, 2) == 0) pulseReset();
      endcase
      step($urandom_range(1, 90));
    end

    step(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
